// File: rtl/oram_avalon_bridge.sv
// Purpose : Avalon-MM word slave bridged onto a block-granular ORAM core; word writes use read-modify-write.
// Latency : read = accept + RD_ISSUE + core wait + RESP; write = accept + read leg + MERGE + write leg.
// Backpr. : waitrequest is low only in IDLE; the core's completion time is unbounded and stalls the slave.
// Ports   : clock/reset (async active-low); avs_data_* Avalon-MM slave; rw_block_number, rw_indicator,
//           input_ready, w_value command the core; r_value and output_ready return its results.
module oram_avalon_bridge #(
    parameter int  ADDRESS_WIDTH   = 4,
    parameter int  BYTE_WIDTH      = 8,
    parameter int  BYTES_PER_WORD  = 4,
    parameter int  BYTES_PER_BLOCK = 8,
    localparam int WORDS_PER_BLOCK = BYTES_PER_BLOCK / BYTES_PER_WORD,
    localparam int OFS_W           = $clog2(WORDS_PER_BLOCK),
    localparam int TREE_DEPTH      = ADDRESS_WIDTH - OFS_W,
    localparam int WORD_W          = BYTES_PER_WORD * BYTE_WIDTH,
    localparam int BLOCK_W         = BYTES_PER_BLOCK * BYTE_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDRESS_WIDTH-1:0]  avs_data_address,
    input  logic [BYTES_PER_WORD-1:0] avs_data_byteenable,
    input  logic                      avs_data_read,
    input  logic                      avs_data_write,
    input  logic [WORD_W-1:0]         avs_data_writedata,
    output logic [WORD_W-1:0]         avs_data_readdata,
    output logic                      avs_data_readdatavalid,
    output logic                      avs_data_waitrequest,
    output logic [TREE_DEPTH-1:0]     rw_block_number,
    output logic                      rw_indicator,
    output logic                      input_ready,
    output logic [BLOCK_W-1:0]        w_value,
    input  logic [BLOCK_W-1:0]        r_value,
    input  logic                      output_ready
);

    // Offset register is kept at least one bit wide; it is constant zero for single-word blocks.
    localparam int OFS_WX      = (OFS_W > 0) ? OFS_W : 1;
    localparam bit SINGLE_WORD = (WORDS_PER_BLOCK == 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_MERGE    = 3'd3;
    localparam logic [2:0] S_WR_ISSUE = 3'd4;
    localparam logic [2:0] S_WR_WAIT  = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    logic [2:0]                r_state;
    logic [TREE_DEPTH-1:0]     r_blk_num;
    logic [OFS_WX-1:0]         r_ofs;
    logic [BYTES_PER_WORD-1:0] r_be;
    logic [WORD_W-1:0]         r_wdata;
    logic                      r_is_wr;
    logic                      r_rw;
    logic [BLOCK_W-1:0]        r_blk_data;
    logic [BLOCK_W-1:0]        r_wval;
    logic [WORD_W-1:0]         r_rdata;

    logic [TREE_DEPTH-1:0]     w_blk;
    logic [OFS_WX-1:0]         w_ofs;
    logic [WORD_W-1:0]         w_rd_word;
    logic [BLOCK_W-1:0]        w_merged;
    logic                      w_accept;
    logic                      w_direct_wr;

    generate
        if (OFS_W > 0) begin : g_ofs
            assign w_blk = avs_data_address[ADDRESS_WIDTH-1:OFS_W];
            assign w_ofs = avs_data_address[OFS_W-1:0];
        end else begin : g_no_ofs
            assign w_blk = avs_data_address;
            assign w_ofs = '0;
        end
    endgenerate

    assign w_accept    = (r_state == S_IDLE) && (avs_data_read || avs_data_write);
    // A full-lane write into a one-word block overwrites everything, so the read leg is pointless.
    assign w_direct_wr = avs_data_write && SINGLE_WORD && (&avs_data_byteenable);

    // Word selected from the block the core is returning right now.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            if (OFS_WX'(k) == r_ofs) begin
                w_rd_word = r_value[k*WORD_W +: WORD_W];
            end
        end
    end

    // Captured block with only the enabled lanes of the addressed word replaced.
    always_comb begin
        w_merged = r_blk_data;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if ((OFS_WX'(k) == r_ofs) && r_be[i]) begin
                    w_merged[k*WORD_W + i*BYTE_WIDTH +: BYTE_WIDTH] = r_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_blk_num  <= '0;
            r_ofs      <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
            r_rw       <= 1'b0;
            r_blk_data <= '0;
            r_wval     <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_blk_num <= w_blk;
                        r_ofs     <= w_ofs;
                        r_be      <= avs_data_byteenable;
                        r_wdata   <= avs_data_writedata;
                        // Simultaneous read+write is treated as a write.
                        r_is_wr   <= avs_data_write;
                        if (w_direct_wr) begin
                            r_wval  <= BLOCK_W'(avs_data_writedata);
                            r_rw    <= 1'b1;
                            r_state <= S_WR_ISSUE;
                        end else begin
                            r_rw    <= 1'b0;
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (output_ready) begin
                        r_blk_data <= r_value;
                        if (r_is_wr) begin
                            r_state <= S_MERGE;
                        end else begin
                            r_rdata <= w_rd_word;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_MERGE: begin
                    r_wval  <= w_merged;
                    r_rw    <= 1'b1;
                    r_state <= S_WR_ISSUE;
                end
                S_WR_ISSUE: r_state <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (output_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avs_data_waitrequest   = (r_state != S_IDLE);
    assign avs_data_readdatavalid = (r_state == S_RESP);
    assign avs_data_readdata      = r_rdata;
    assign input_ready            = (r_state == S_RD_ISSUE) || (r_state == S_WR_ISSUE);
    assign rw_indicator           = r_rw;
    assign rw_block_number        = r_blk_num;
    assign w_value                = r_wval;

endmodule
